// File: rtl/fifo32to128.sv
// fifo32to128: upsizing FIFO. Packs 32-bit words into 128-bit entries
// (chunk0 -> [31:0] ... chunk3 -> [127:96]), stores FIFO_DEPTH entries and
// pops one registered entry per read_en.
// Optional feature macro: FIFO32TO128_FLUSH_EN adds a flush input that pushes
// a partially packed entry with the missing upper chunks zeroed.
module fifo32to128 #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PTR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic [31:0]      data_in,
  output logic             wr_ready,
  input  logic             read_en,
  output logic [127:0]     data_out,
  output logic             data_valid,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   level,
  output logic             overflow
`ifdef FIFO32TO128_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic [1:0]       chunk_cnt;
  logic [95:0]      pack;
  logic [127:0]     mem [FIFO_DEPTH];
  logic [127:0]     merged;
  logic             accept;
  logic             do_read;
  logic             flush_push;
  logic             push;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);
  assign level    = wptr - rptr;
  assign wr_ready = (chunk_cnt != 2'd3) || !full;
  assign accept   = write_en && wr_ready;
  assign do_read  = read_en && !empty;

`ifdef FIFO32TO128_FLUSH_EN
  assign flush_push = flush && ((chunk_cnt != 2'd0) || accept) && !full;
`else
  assign flush_push = 1'b0;
`endif

  assign push = (accept && (chunk_cnt == 2'd3)) || flush_push;

  // Entry as it would look after this cycle's word lands; pack is cleared on
  // every push, so slots above chunk_cnt are already zero for a flush.
  always_comb begin
    merged = {32'h0, pack};
    if (accept) begin
      case (chunk_cnt)
        2'd0:    merged[31:0]   = data_in;
        2'd1:    merged[63:32]  = data_in;
        2'd2:    merged[95:64]  = data_in;
        default: merged[127:96] = data_in;
      endcase
    end
  end

  // Packing state, write pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_cnt <= 2'd0;
      pack      <= '0;
      wptr      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        pack      <= '0;
        chunk_cnt <= 2'd0;
        wptr      <= wptr + 1'b1;
      end else if (accept) begin
        pack      <= merged[95:0];
        chunk_cnt <= chunk_cnt + 2'd1;
      end
      if (write_en && !wr_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[PTR_W-1:0]] <= merged;
    end
  end

  // Read side: registered output, valid for one cycle per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (do_read) begin
        data_out   <= mem[rptr[PTR_W-1:0]];
        rptr       <= rptr + 1'b1;
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo32to128.sv
// Self-checking bench for fifo32to128: directed vector table plus
// hand-written multi-cycle sequences against a small behavioural model.
module tb_fifo32to128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_en;
  logic [31:0]  data_in;
  logic         wr_ready;
  logic         read_en;
  logic [127:0] data_out;
  logic         data_valid;
  logic         empty;
  logic         full;
  logic [4:0]   level;
  logic         overflow;
  logic         flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo32to128 #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .data_in    (data_in),
    .wr_ready   (wr_ready),
    .read_en    (read_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow)
`ifdef FIFO32TO128_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  typedef struct {
    logic         we;
    logic [31:0]  din;
    logic         re;
    logic         rdy;
    logic         emp;
    logic [4:0]   lvl;
    logic         dv;
    logic [127:0] dout;
  } vec_t;

  vec_t vt[16];

  // behavioural model state
  logic [31:0]  m_pack[3];
  int           m_cnt;
  logic         m_ovf;
  logic         m_acc;
  logic [127:0] mq[$];
  logic [31:0]  in_w[$];
  logic [31:0]  out_w[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic step(input logic we, input logic [31:0] d, input logic re, input logic fl);
    write_en = we;
    data_in  = d;
    read_en  = re;
    flush    = fl;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_ovf = 1'b0;
    mq.delete();
    for (int i = 0; i < 3; i++) m_pack[i] = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_data_out", data_out, 128'h0);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
  endtask

  // Asynchronous reset pulse taken between clock edges, checked while asserted.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // One cycle against the model: checks pre-edge wr_ready, then post-edge state.
  task automatic mcycle(input logic we, input logic [31:0] d, input logic re, input logic fl);
    logic         exp_rdy;
    logic         pop;
    logic         fpush;
    logic [127:0] exp_d;
    logic [127:0] ent;
    exp_rdy = (m_cnt != 3) || (mq.size() != 16);
    chk("wr_ready", wr_ready, exp_rdy);
    m_acc = we && exp_rdy;
    pop   = re && (mq.size() != 0);
    exp_d = pop ? mq[0] : data_out;
    fpush = fl && ((m_cnt != 0) || m_acc) && (mq.size() != 16);
    ent = '0;
    for (int i = 0; i < m_cnt; i++) ent[32*i +: 32] = m_pack[i];
    if (m_acc) ent[32*m_cnt +: 32] = d;
    if (we && !exp_rdy) m_ovf = 1'b1;
    step(we, d, re, fl);
    if (pop) void'(mq.pop_front());
    if ((m_acc && m_cnt == 3) || fpush) begin
      mq.push_back(ent);
      m_cnt = 0;
      for (int i = 0; i < 3; i++) m_pack[i] = '0;
    end else if (m_acc) begin
      m_pack[m_cnt] = d;
      m_cnt++;
    end
    chk("data_valid", data_valid, pop);
    if (pop) begin
      chk("data_out", data_out, exp_d);
      for (int i = 0; i < 4; i++) out_w.push_back(data_out[32*i +: 32]);
    end
    chk("level", level, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 16);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() != 0; i++) mcycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained_empty", empty, 1'b1);
  endtask

  localparam logic [127:0] E1 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] E2 = 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001;
  localparam logic [127:0] E3 = 128'hB0000004_B0000003_B0000002_B0000001;

  initial begin
    //          we    din            re    rdy   emp   lvl   dv    dout
    vt[0]  = '{1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 128'h0};
    vt[1]  = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 128'h0};
    vt[2]  = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 128'h0};
    vt[3]  = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 128'h0};
    vt[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 5'd0, 1'b1, E1};
    vt[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd0, 1'b0, E1};
    vt[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 5'd0, 1'b0, E1};
    vt[7]  = '{1'b1, 32'hAAAA0001, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, E1};
    vt[8]  = '{1'b1, 32'hAAAA0002, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, E1};
    vt[9]  = '{1'b1, 32'hAAAA0003, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, E1};
    vt[10] = '{1'b1, 32'hAAAA0004, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, E1};
    vt[11] = '{1'b1, 32'hB0000001, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, E1};
    vt[12] = '{1'b1, 32'hB0000002, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, E1};
    vt[13] = '{1'b1, 32'hB0000003, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, E1};
    vt[14] = '{1'b1, 32'hB0000004, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, E2};
    vt[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 5'd0, 1'b1, E3};

    rst_n    = 1'b0;
    write_en = 1'b0;
    data_in  = '0;
    read_en  = 1'b0;
    flush    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // packing, pop latency, empty reads, simultaneous completing write + read
    for (int i = 0; i < 16; i++) begin
      step(vt[i].we, vt[i].din, vt[i].re, 1'b0);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, vt[i].rdy);
      chk($sformatf("vec%0d_empty", i), empty, vt[i].emp);
      chk($sformatf("vec%0d_level", i), level, vt[i].lvl);
      chk($sformatf("vec%0d_data_valid", i), data_valid, vt[i].dv);
      chk($sformatf("vec%0d_data_out", i), data_out, vt[i].dout);
    end

    // full / overflow: 16 entries, then 3 words leaves wr_ready low
    do_reset();
    for (int k = 0; k < 64; k++) mcycle(1'b1, 32'hC000_0000 + k, 1'b0, 1'b0);
    chk("t3_full", full, 1'b1);
    for (int k = 0; k < 3; k++) mcycle(1'b1, 32'hD000_0000 + k, 1'b0, 1'b0);
    chk("t3_wr_ready_low", wr_ready, 1'b0);
    mcycle(1'b1, 32'hDEAD0001, 1'b0, 1'b0);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_level16", level, 5'd16);
    // a pop in the same cycle does not make room for the completing word
    mcycle(1'b1, 32'hDEAD0002, 1'b1, 1'b0);
    mcycle(1'b1, 32'hD0000003, 1'b0, 1'b0);
    drain();

    // reset mid-pack discards the partial entry and clears overflow
    mcycle(1'b1, 32'hEEEE0001, 1'b0, 1'b0);
    mcycle(1'b1, 32'hEEEE0002, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) mcycle(1'b1, 32'hF000_0000 + k, 1'b0, 1'b0);
    mcycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_fresh_pack", data_out, 128'hF0000003_F0000002_F0000001_F0000000);

    // simultaneous completing write and read at level 5
    do_reset();
    for (int k = 0; k < 23; k++) mcycle(1'b1, 32'h5000_0000 + k, 1'b0, 1'b0);
    mcycle(1'b1, 32'h5000_0017, 1'b1, 1'b0);
    chk("t4_level5", level, 5'd5);
    drain();

    // wrap / loopback with random reads
    do_reset();
    in_w.delete();
    out_w.delete();
    for (int k = 0; k < 2000 && in_w.size() < 160; k++) begin
      logic [31:0] w;
      w = 32'h7000_0000 + in_w.size();
      mcycle(1'b1, w, 1'($urandom_range(0, 1)), 1'b0);
      if (m_acc) in_w.push_back(w);
    end
    drain();
    chk("t5_word_count", out_w.size(), in_w.size());
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < in_w.size() && i < out_w.size(); i++)
        if (out_w[i] !== in_w[i]) bad++;
      chk("t5_loopback_mismatches", bad, 0);
    end

`ifdef FIFO32TO128_FLUSH_EN
    // flush of a partial entry, flush merged with a write, then a normal pack
    do_reset();
    mcycle(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    mcycle(1'b1, 32'hBBBBBBBB, 1'b0, 1'b0);
    mcycle(1'b0, 32'h0, 1'b0, 1'b1);
    mcycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_flush_entry", data_out, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    mcycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t6_flush_noop_level", level, 5'd0);
    mcycle(1'b1, 32'hCCCCCCCC, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) mcycle(1'b1, 32'h6000_0000 + k, 1'b0, 1'b0);
    mcycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_flush_with_write", data_out, 128'h00000000_00000000_00000000_CCCCCCCC);
    mcycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_after_flush", data_out, 128'h60000003_60000002_60000001_60000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
